// File: rtl/bank_unloader.sv
// Streams the N transformed coefficients out of the four data banks in natural order.
// Optional build macro: BIT_REVERSE_EN (map_old_addr is the bit-reversed index).
module bank_unloader #(
    parameter int N          = 128,
    parameter int AW         = 7,
    parameter int BW         = 5,
    parameter int DW         = 12,
    parameter int MAP_LAT    = 1,
    parameter int BANK_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] map_old_addr,
    input  logic [1:0]    map_bank,
    input  logic [BW-1:0] map_new_addr,
    output logic [3:0]    rd_bank_en,
    output logic [BW-1:0] rd_addr,
    input  logic [DW-1:0] q0,
    input  logic [DW-1:0] q1,
    input  logic [DW-1:0] q2,
    input  logic [DW-1:0] q3,
    output logic [DW-1:0] dout,
    output logic [AW-1:0] dout_idx,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic          busy,
    output logic          done
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d, addr_q, addr_next;
    logic           issue, pop, push, credit, pipe_empty;
    logic [7:0]     inflight, occ;

    logic [MAP_LAT-1:0]  mv_q;
    logic [AW-1:0]       midx_q [MAP_LAT];
    logic [BANK_LAT-1:0] bv_q;
    logic [AW-1:0]       bidx_q [BANK_LAT];
    logic [1:0]          bsel_q [BANK_LAT];

    logic [DW-1:0]  fd_q [FIFO_DEPTH];
    logic [AW-1:0]  fi_q [FIFO_DEPTH];
    logic [PW-1:0]  wp_q, rp_q;
    logic [CW-1:0]  fc_q;
    logic [DW-1:0]  qsel;

    function automatic logic [AW-1:0] map_addr(input logic [AW-1:0] c);
        logic [AW-1:0] r;
`ifdef BIT_REVERSE_EN
        for (int unsigned i = 0; i < AW; i++) r[i] = c[AW-1-i];
`else
        r = c;
`endif
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers every issued entry not yet popped, so the FIFO can never overflow.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MAP_LAT; i++)  inflight = inflight + 8'(mv_q[i]);
        for (int unsigned i = 0; i < BANK_LAT; i++) inflight = inflight + 8'(bv_q[i]);
        occ        = inflight + 8'(fc_q);
        credit     = occ < 8'(FIFO_DEPTH);
        pipe_empty = (inflight == '0);
    end

    assign dout_valid = (fc_q != '0);
    assign pop        = dout_valid & dout_ready;
    assign push       = bv_q[BANK_LAT-1];
    assign dout       = fd_q[rp_q];
    assign dout_idx   = fi_q[rp_q];
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign addr_next  = map_addr(cnt_q);
    assign map_old_addr = issue ? addr_next : addr_q;
    assign rd_bank_en = mv_q[MAP_LAT-1] ? (4'b0001 << map_bank) : 4'b0000;
    assign rd_addr    = mv_q[MAP_LAT-1] ? map_new_addr : '0;

    always_comb begin
        case (bsel_q[BANK_LAT-1])
            2'd0:    qsel = q0;
            2'd1:    qsel = q1;
            2'd2:    qsel = q2;
            default: qsel = q3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                cnt_d   = '0;
            end
            RUN: if (credit) begin
                issue = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(N - 1)) state_d = DRAIN;
            end
            // Leave as the final pop happens so done lands in the following cycle.
            DRAIN: if (pipe_empty && ((fc_q == '0) || ((fc_q == CW'(1)) && pop)))
                state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            mv_q    <= '0;
            bv_q    <= '0;
            for (int unsigned i = 0; i < MAP_LAT; i++) midx_q[i] <= '0;
            for (int unsigned i = 0; i < BANK_LAT; i++) begin
                bidx_q[i] <= '0;
                bsel_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue) addr_q <= addr_next;
            mv_q[0]   <= issue;
            midx_q[0] <= cnt_q;
            for (int unsigned i = 1; i < MAP_LAT; i++) begin
                mv_q[i]   <= mv_q[i-1];
                midx_q[i] <= midx_q[i-1];
            end
            bv_q[0]   <= mv_q[MAP_LAT-1];
            bidx_q[0] <= midx_q[MAP_LAT-1];
            bsel_q[0] <= map_bank;
            for (int unsigned i = 1; i < BANK_LAT; i++) begin
                bv_q[i]   <= bv_q[i-1];
                bidx_q[i] <= bidx_q[i-1];
                bsel_q[i] <= bsel_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
            fc_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fd_q[i] <= '0;
                fi_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fd_q[wp_q] <= qsel;
                fi_q[wp_q] <= bidx_q[BANK_LAT-1];
                wp_q       <= ptr_inc(wp_q);
            end
            if (pop) rp_q <= ptr_inc(rp_q);
            fc_q <= fc_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && !pop && (fc_q == CW'(FIFO_DEPTH))));
    end

endmodule

// File: tb/tb_bank_unloader.sv
// Scoreboard bench for bank_unloader: reference map + bank model, randomized ready, queue-based checking.
module tb_bank_unloader;
    localparam int N = 128, AW = 7, BW = 5, DW = 12, DEPTH = 4;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, dout_ready = 1'b1;
    logic [AW-1:0] map_old_addr, dout_idx, seen_addr = '0;
    logic [1:0]    map_bank = '0;
    logic [BW-1:0] map_new_addr = '0, rd_addr;
    logic [3:0]    rd_bank_en;
    logic [DW-1:0] qa [4];
    logic [DW-1:0] dout;
    logic          dout_valid, busy, done;
    logic [DW-1:0] mem [4][32];

    bank_unloader #(.N(N), .AW(AW), .BW(BW), .DW(DW), .MAP_LAT(1), .BANK_LAT(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .map_old_addr(map_old_addr), .map_bank(map_bank),
        .map_new_addr(map_new_addr), .rd_bank_en(rd_bank_en), .rd_addr(rd_addr),
        .q0(qa[0]), .q1(qa[1]), .q2(qa[2]), .q3(qa[3]), .dout(dout), .dout_idx(dout_idx),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .done(done));

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] bank_of(input logic [AW-1:0] a);
        return a[1:0] ^ a[3:2];
    endfunction
    function automatic logic [BW-1:0] addr_of(input logic [AW-1:0] a);
        return a[6:2];
    endfunction
    function automatic int rev(input int x);
        int r = 0;
        for (int i = 0; i < AW; i++) begin
            r = (r << 1) | (x & 1);
            x = x >> 1;
        end
        return r;
    endfunction
    function automatic int ref_old(input int n);
`ifdef BIT_REVERSE_EN
        return rev(n);
`else
        return n;
`endif
    endfunction

    // Reference memory map (registered, one cycle) and bank model; unselected banks return noise.
    always @(posedge clk) begin
        seen_addr    <= map_old_addr;
        map_bank     <= bank_of(map_old_addr);
        map_new_addr <= addr_of(map_old_addr);
        for (int b = 0; b < 4; b++)
            qa[b] <= rd_bank_en[b] ? mem[b][rd_addr] : DW'($urandom);
    end

    int            exp_idx[$];
    logic [DW-1:0] exp_val[$];
    int            xfers = 0, reads = 0, issue_n = 0, done_cnt = 0;
    bit            final_seen = 0, hold = 0;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_i;

    always @(negedge clk) begin
        if (rst) begin
            hold       = 0;
            final_seen = 0;
        end else begin
            if (rd_bank_en != 4'b0000) begin
                chk("rd_bank_en", 32'(rd_bank_en), 32'(4'b0001 << bank_of(seen_addr)));
                chk("rd_addr", 32'(rd_addr), 32'(addr_of(seen_addr)));
                chk("issue_order", 32'(seen_addr), ref_old(issue_n));
                issue_n++;
                reads++;
            end
            chk("credit", 32'(reads - xfers <= DEPTH), 1);
            if (hold) begin
                chk("hold_valid", 32'(dout_valid), 1);
                chk("hold_dout", 32'(dout), 32'(hold_d));
                chk("hold_idx", 32'(dout_idx), 32'(hold_i));
            end
            chk("done", 32'(done), 32'(final_seen));
            final_seen = 0;
            if (done) done_cnt++;
            if (dout_valid && dout_ready) begin
                if (exp_idx.size() == 0) begin
                    chk("sb_underflow", 32'(exp_idx.size()), 1);
                end else begin
                    chk("dout_idx", 32'(dout_idx), exp_idx.pop_front());
                    chk("dout", 32'(dout), 32'(exp_val.pop_front()));
                end
                xfers++;
                if (xfers == N) final_seen = 1;
            end
            hold   = dout_valid && !dout_ready;
            hold_d = dout;
            hold_i = dout_idx;
        end
    end

    // mode: 0 ready=1, 1 stall window, 2 random ready, 3 re-pulse start, 4 reset mid-stream
    task automatic run(input int mode);
        int k;
        bit fin, seen_v, pulsed;
        exp_idx.delete();
        exp_val.delete();
        for (int i = 0; i < N; i++) begin
            exp_idx.push_back(i);
            exp_val.push_back(DW'(12'h100 + i));
        end
        xfers = 0; reads = 0; issue_n = 0; done_cnt = 0;
        fin = 0; seen_v = 0; pulsed = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        k = 0;
        while (!fin && k < 3000) begin
            #1;
            start = 1'b0;
            dout_ready = (mode == 1) ? !(k >= 5 && k <= 20) :
                         (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!seen_v && dout_valid) begin
                seen_v = 1;
                chk("latency", k, 3);
            end
            if (mode == 0 && (k == 1 || k == 3)) chk("map_old_addr", 32'(map_old_addr), ref_old(k));
            if (mode == 1 && k >= 14 && k <= 20) begin
                chk("stall_no_read", 32'(rd_bank_en), 0);
                chk("stall_fill", reads, xfers + DEPTH);
            end
            if (mode == 3 && !pulsed && xfers == 41) begin
                start  = 1'b1;
                pulsed = 1;
            end
            if (mode == 4 && xfers >= 60) begin
                rst = 1'b1;
                #1;
                chk("rst_outs_a", {map_old_addr, rd_bank_en, rd_addr, dout_valid, busy, done}, 0);
                chk("rst_outs_b", {dout, dout_idx}, 0);
                fin = 1;
            end else if (done) begin
                chk("busy_at_done", 32'(busy), 0);
                if (mode == 0) chk("total_cycles", k, N + 3);
                fin = 1;
            end else begin
                chk("busy", 32'(busy), 1);
            end
            if (!fin) begin
                @(posedge clk);
                k++;
            end
        end
        if (!fin) chk("timeout_done", 32'(done), 1);
        if (mode == 4) begin
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end else begin
            repeat (3) @(posedge clk);
            #1;
            chk("done_once", done_cnt, 1);
            chk("xfer_total", xfers, N);
            chk("sb_empty", exp_idx.size(), 0);
            chk("idle_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        for (int a = 0; a < N; a++) begin
            logic [AW-1:0] av;
            int nat;
            av  = AW'(a);
`ifdef BIT_REVERSE_EN
            nat = rev(a);
`else
            nat = a;
`endif
            mem[bank_of(av)][addr_of(av)] = DW'(12'h100 + nat);
        end
        #3;
        chk("reset_outs_a", {map_old_addr, rd_bank_en, rd_addr, dout_valid, busy, done}, 0);
        chk("reset_outs_b", {dout, dout_idx}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run(0);
        run(1);
        run(2);
        run(3);
        run(4);
        run(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
